// File: rtl/fp16_to_fp32_cvt.sv
// FP16 -> FP32 widening stage behind the FP16 multiplier, with valid/ready on both sides.
// Define FP16CVT_FTZ_EN to flush subnormal inputs to signed zero instead of normalising them.
module fp16_to_fp32_cvt #(
  parameter int unsigned BIAS16 = 15,
  parameter int unsigned BIAS32 = 127
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_flags,
  output logic        busy
);

  localparam logic [7:0] EXP_ADJ  = 8'(BIAS32 - BIAS16);
  localparam logic [7:0] SUB_BASE = 8'(BIAS32 - BIAS16 + 1);

`ifdef FP16CVT_FTZ_EN
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
`endif

  state_t      state, stateNext, classNext;
  logic        inXfer, outXfer;
  logic        sIn;
  logic [4:0]  eIn;
  logic [9:0]  fIn;
  logic [31:0] fastData;
  logic [31:0] outData;
  logic [3:0]  outFlags;
  logic [18:0] unusedBits;

`ifndef FP16CVT_FTZ_EN
  logic        isSub;
  logic        sReg, ovfReg;
  logic [9:0]  mReg;
  logic [3:0]  kReg, kNext;
  logic [10:0] mShift;
  logic [31:0] normData;
`endif

  function automatic logic [3:0] mkFlags(input logic ovf, input logic [31:0] d);
    return {ovf, d[30:0] == '0, 1'b0, d[31]};
  endfunction

  assign unusedBits = {in_data[31:16], in_flags[2:0]};
  assign sIn        = in_data[15];
  assign eIn        = in_data[14:10];
  assign fIn        = in_data[9:0];
  assign inXfer     = in_valid && in_ready;
  assign outXfer    = out_valid && out_ready;

  // Single-cycle path; e==0 falls through to signed zero (also the FTZ result).
  always_comb begin
    fastData = {sIn, 31'b0};
    if (eIn == 5'd31) begin
      if (fIn == '0) fastData = {sIn, 8'hFF, 23'b0};
      else           fastData = {sIn, 8'hFF, 1'b1, fIn[8:0], 13'b0};
    end else if (eIn != '0) begin
      fastData = {sIn, {3'b000, eIn} + EXP_ADJ, fIn, 13'b0};
    end
  end

`ifndef FP16CVT_FTZ_EN
  assign isSub  = (eIn == '0) && (fIn != '0);
  assign mShift = {mReg, 1'b0};
  assign kNext  = kReg + 4'd1;
  // Result is formed from the post-shift mantissa so DONE is entered with it already registered.
  assign normData = {sReg, SUB_BASE - {4'b0000, kNext}, mShift[9:0], 13'b0};
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
`ifdef FP16CVT_FTZ_EN
    classNext = DONE;
`else
    classNext = isSub ? NORM : DONE;
`endif
    stateNext = state;
    unique case (state)
      IDLE: if (inXfer) stateNext = classNext;
`ifndef FP16CVT_FTZ_EN
      NORM: if (mShift[10]) stateNext = DONE;
`endif
      DONE: begin
        if (inXfer)       stateNext = classNext;
        else if (outXfer) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    out_valid = (state == DONE);
`ifdef FP16CVT_FTZ_EN
    busy      = 1'b0;
`else
    busy      = (state == NORM);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outData  <= '0;
      outFlags <= '0;
`ifndef FP16CVT_FTZ_EN
      mReg     <= '0;
      kReg     <= '0;
      sReg     <= 1'b0;
      ovfReg   <= 1'b0;
`endif
    end else if (inXfer) begin
`ifdef FP16CVT_FTZ_EN
      outData  <= fastData;
      outFlags <= mkFlags(in_flags[3], fastData);
`else
      sReg   <= sIn;
      ovfReg <= in_flags[3];
      mReg   <= fIn;
      kReg   <= '0;
      if (!isSub) begin
        outData  <= fastData;
        outFlags <= mkFlags(in_flags[3], fastData);
      end
`endif
    end
`ifndef FP16CVT_FTZ_EN
    else if (state == NORM) begin
      mReg <= mShift[9:0];
      kReg <= kNext;
      if (mShift[10]) begin
        outData  <= normData;
        outFlags <= mkFlags(ovfReg, normData);
      end
    end
`endif
  end

  assign out_data  = outData;
  assign out_flags = outFlags;

endmodule
